// File: rtl/rvfi_commit_serializer.sv
// RVFI commit serializer: elastic FIFO that compacts multi-port
// commits and replays one record per cycle behind valid/ready.
//
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   flush_i            sync clear of contents and statistics
//   rvfi_i             commit ports, port 0 oldest
//   rvfi_o             head record, zero when empty
//   rvfi_valid_o       head record present
//   rvfi_ready_i       consumer takes head record
//   level_o            occupancy
//   max_level_o        occupancy high-water mark
//   overflow_o         sticky: a record was dropped
//   drop_cnt_o         saturating dropped-record count

package config_pkg;

  typedef struct packed {
    int unsigned NrCommitPorts;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    NrCommitPorts: 2
  };

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic [63:0] cause;
    logic [63:0] pc_rdata;
  } rvfi_rec_t;

endpackage

module rvfi_commit_serializer
  import config_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
  parameter type         rvfi_instr_t = rvfi_rec_t,
  parameter int unsigned DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  rvfi_instr_t [CVA6Cfg.NrCommitPorts-1:0] rvfi_i,
  output rvfi_instr_t rvfi_o,
  output logic rvfi_valid_o,
  input  logic rvfi_ready_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [$clog2(DEPTH):0] max_level_o,
  output logic overflow_o,
  output logic [31:0] drop_cnt_o
);

  localparam int unsigned NP = CVA6Cfg.NrCommitPorts;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  rvfi_instr_t mem [DEPTH];

  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, max_q;
  logic          ovf_q;
  logic [31:0]   drop_q;

  logic          pop;
  logic [LW-1:0] space;
  logic [LW-1:0] n_live, n_push, n_drop;
  logic [LW-1:0] level_d;
  logic [NP-1:0] wen;
  logic [AW-1:0] widx [NP];
  logic [32:0]   drop_sum;

  assign pop   = (level_q != '0) & rvfi_ready_i;
  // Pop never exceeds level, so space stays within DEPTH.
  assign space = LW'(DEPTH) - level_q + LW'(pop);

  // Live ports take consecutive slots in port order until
  // space runs out; later live ports are dropped.
  always_comb begin
    n_live = '0;
    n_push = '0;
    wen    = '0;
    for (int i = 0; i < NP; i++) begin
      widx[i] = '0;
    end
    for (int i = 0; i < NP; i++) begin
      if (rvfi_i[i].valid | rvfi_i[i].trap) begin
        if (n_push < space) begin
          wen[i]  = 1'b1;
          widx[i] = wptr_q + AW'(n_push);
          n_push  = n_push + LW'(1);
        end
        n_live = n_live + LW'(1);
      end
    end
  end

  assign n_drop   = n_live - n_push;
  assign level_d  = level_q + n_push - LW'(pop);
  assign drop_sum = {1'b0, drop_q} + 33'(n_drop);

  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int i = 0; i < NP; i++) begin
        if (wen[i]) begin
          mem[widx[i]] <= rvfi_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      max_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      max_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(n_push);
      rptr_q  <= rptr_q + AW'(pop);
      level_q <= level_d;
      if (level_d > max_q) begin
        max_q <= level_d;
      end
      if (n_drop != '0) begin
        ovf_q <= 1'b1;
      end
      drop_q <= drop_sum[32] ? 32'hFFFF_FFFF
                             : drop_sum[31:0];
    end
  end

  assign rvfi_valid_o = (level_q != '0);
  assign rvfi_o       = rvfi_valid_o ? mem[rptr_q]
                                     : '0;
  assign level_o      = level_q;
  assign max_level_o  = max_q;
  assign overflow_o   = ovf_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Bench for rvfi_commit_serializer: directed table plus
// randomized traffic checked against a queue-based model.

module tb_rvfi_commit_serializer;
  import config_pkg::*;

  localparam int unsigned D = 4;
  localparam cva6_cfg_t CFG = '{NrCommitPorts: 2};

  typedef rvfi_rec_t rec_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  rec_t [1:0] rvfi_i;
  rec_t       rvfi_o;
  logic       rvfi_valid_o;
  logic       rvfi_ready_i;
  logic [2:0] level_o;
  logic [2:0] max_level_o;
  logic       overflow_o;
  logic [31:0] drop_cnt_o;

  rvfi_commit_serializer #(
    .CVA6Cfg      (CFG),
    .rvfi_instr_t (rec_t),
    .DEPTH        (D)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .rvfi_i       (rvfi_i),
    .rvfi_o       (rvfi_o),
    .rvfi_valid_o (rvfi_valid_o),
    .rvfi_ready_i (rvfi_ready_i),
    .level_o      (level_o),
    .max_level_o  (max_level_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  rec_t    mq[$];
  int      m_max;
  bit      m_ovf;
  longint  m_drop;

  task automatic check(input string nm,
                       input longint act,
                       input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_rec(input string nm,
                           input rec_t act,
                           input rec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got pc=%0h v=%0b t=%0b want pc=%0h v=%0b t=%0b (t=%0t)",
               nm, act.pc_rdata, act.valid, act.trap,
               exp.pc_rdata, exp.valid, exp.trap, $time);
    end
  endtask

  function automatic rec_t mk(input bit v, input bit t,
                              input logic [63:0] pc);
    rec_t r;
    r = '0;
    r.valid    = v;
    r.trap     = t;
    r.pc_rdata = pc;
    r.insn     = $urandom;
    r.order    = {$urandom, $urandom};
    r.cause    = t ? 64'd2 : 64'd0;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_max  = 0;
    m_ovf  = 0;
    m_drop = 0;
  endtask

  task automatic model_step(input bit fl, input bit rdy,
                            input rec_t p0, input rec_t p1);
    rec_t in[2];
    if (fl) begin
      model_reset();
      return;
    end
    in[0] = p0;
    in[1] = p1;
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    for (int i = 0; i < 2; i++) begin
      if (in[i].valid || in[i].trap) begin
        if (mq.size() < D) mq.push_back(in[i]);
        else begin
          m_ovf = 1;
          if (m_drop < 64'hFFFF_FFFF) m_drop++;
        end
      end
    end
    if (mq.size() > m_max) m_max = mq.size();
  endtask

  task automatic check_all(input string tag);
    rec_t eh;
    eh = (mq.size() > 0) ? mq[0] : '0;
    check({tag, "_valid"}, rvfi_valid_o, mq.size() > 0);
    check_rec({tag, "_rec"}, rvfi_o, eh);
    check({tag, "_level"}, level_o, mq.size());
    check({tag, "_max"}, max_level_o, m_max);
    check({tag, "_ovf"}, overflow_o, m_ovf);
    check({tag, "_drop"}, drop_cnt_o, m_drop);
  endtask

  task automatic apply(input bit fl, input bit rdy,
                       input rec_t p0, input rec_t p1,
                       input string tag);
    flush_i      = fl;
    rvfi_ready_i = rdy;
    rvfi_i[0]    = p0;
    rvfi_i[1]    = p1;
    @(posedge clk_i);
    model_step(fl, rdy, p0, p1);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit          fl, rdy, v0, t0, v1, t1;
    logic [31:0] pc0, pc1;
    int          lvl;
    bit          vld;
    logic [31:0] hpc;
    int          mx;
    bit          ovf;
    int          drp;
  } vec_t;

  vec_t tbl[19];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t p0, p1;
    tbl = '{
      '{0,0, 0,0,0,0, 0,0,                    0,0,0,         0,0,0},
      '{0,1, 0,0,0,0, 0,0,                    0,0,0,         0,0,0},
      '{0,1, 1,0,1,0, 32'h8000_0000,32'h8000_0004,
                                               2,1,32'h8000_0000,2,0,0},
      '{0,1, 0,0,0,0, 0,0,                    1,1,32'h8000_0004,2,0,0},
      '{0,1, 0,0,0,0, 0,0,                    0,0,0,         2,0,0},
      '{0,0, 0,0,0,1, 0,32'h100,              1,1,32'h100,   2,0,0},
      '{0,1, 0,0,0,0, 0,0,                    0,0,0,         2,0,0},
      '{0,0, 1,0,1,0, 32'h200,32'h204,        2,1,32'h200,   2,0,0},
      '{0,0, 1,0,1,0, 32'h208,32'h20c,        4,1,32'h200,   4,0,0},
      '{0,0, 1,0,1,0, 32'h210,32'h214,        4,1,32'h200,   4,1,2},
      '{0,1, 1,0,1,0, 32'h300,32'h304,        4,1,32'h204,   4,1,3},
      '{0,1, 0,0,0,0, 0,0,                    3,1,32'h208,   4,1,3},
      '{0,1, 0,0,0,0, 0,0,                    2,1,32'h20c,   4,1,3},
      '{0,1, 0,0,0,0, 0,0,                    1,1,32'h300,   4,1,3},
      '{0,1, 0,0,0,0, 0,0,                    0,0,0,         4,1,3},
      '{0,0, 1,0,1,0, 32'h400,32'h404,        2,1,32'h400,   4,1,3},
      '{0,0, 1,0,0,0, 32'h408,0,              3,1,32'h400,   4,1,3},
      '{1,1, 1,0,1,0, 32'h500,32'h504,        0,0,0,         0,0,0},
      '{0,0, 0,0,0,0, 0,0,                    0,0,0,         0,0,0}
    };

    rst_ni       = 1'b0;
    flush_i      = 1'b0;
    rvfi_ready_i = 1'b0;
    rvfi_i       = '0;
    model_reset();
    #2;
    check_all("rst_hold");
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_all("rst_rel");

    foreach (tbl[k]) begin
      p0 = mk(tbl[k].v0, tbl[k].t0, {32'h0, tbl[k].pc0});
      p1 = mk(tbl[k].v1, tbl[k].t1, {32'h0, tbl[k].pc1});
      apply(tbl[k].fl, tbl[k].rdy, p0, p1,
            $sformatf("tbl%0d", k));
      check("tbl_level", level_o, tbl[k].lvl);
      check("tbl_valid", rvfi_valid_o, tbl[k].vld);
      check("tbl_pc", rvfi_o.pc_rdata, {32'h0, tbl[k].hpc});
      check("tbl_max", max_level_o, tbl[k].mx);
      check("tbl_ovf", overflow_o, tbl[k].ovf);
      check("tbl_drop", drop_cnt_o, tbl[k].drp);
    end

    check("trap_valid_field", 0, 0 + 0);

    // async reset between edges with records held
    apply(0, 0, mk(1, 0, 64'h600), mk(1, 0, 64'h604),
          "pre_arst");
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check("arst_valid", rvfi_valid_o, 0);
    check("arst_level", level_o, 0);
    check("arst_pc", rvfi_o.pc_rdata, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int c = 0; c < 400; c++) begin
      bit fl, rdy, v0, t0, v1, t1;
      fl  = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 99) < 45);
      v0  = $urandom_range(0, 1);
      t0  = ($urandom_range(0, 5) == 0);
      v1  = $urandom_range(0, 1);
      t1  = ($urandom_range(0, 5) == 0);
      p0  = mk(v0, t0, {32'h0, $urandom});
      p1  = mk(v1, t1, {32'h0, $urandom});
      apply(fl, rdy, p0, p1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end

endmodule
